scan_decoder: RTL and testbench



---
 rtl/scan_decoder_pkg.sv | 24 ++
 rtl/scan_decoder_scan_timer.sv | 52 +++++
 rtl/scan_decoder.sv | 138 +++++++++++++
 tb/tb_scan_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding,
// mode encoding and a one-hot helper sized for the widest supported select.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers truncate to their own width.
    localparam int ONEHOT_MAX_SEL_W = 8;
    localparam int ONEHOT_MAX_W     = 2 ** ONEHOT_MAX_SEL_W;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_MAX_SEL_W-1:0] sel);
        logic [ONEHOT_MAX_W-1:0] v;
        v = {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1} << sel;
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_scan_timer.sv
// Dwell down-counter for scan mode. Loaded on scan entry, decremented every
// scan cycle, and reloaded from the live dwell value whenever it expires.
// step marks the cycle whose edge advances the index; wrap marks a step
// that takes the index from its last value back to zero.
module scan_timer
    import scan_decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               idx_last,
    output logic               step,
    output logic               wrap
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Next counter value plus step/wrap strobes.
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        wrap  = 1'b0;
        if (load) begin
            cnt_d = dwell;
        end else if (run) begin
            if (cnt_q == {DWELL_W{1'b0}}) begin
                cnt_d = dwell;
                step  = 1'b1;
                wrap  = idx_last;
            end else begin
                cnt_d = cnt_q - DWELL_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; value is retained outside scan mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {DWELL_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a direct (handshaken) mode and an
// autonomous walking-one scan mode with programmable dwell.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;

    logic               accept_s;
    logic               scan_sel_s;
    logic               scan_load_s;
    logic               scan_run_s;
    logic               idx_last_s;
    logic [SEL_W-1:0]   idx_inc_s;
    logic               step_s;
    logic               wrap_s;

    // Handshake: only the enabled, direct-mode, out-of-reset block accepts.
    assign in_ready   = en & (mode == MODE_DIRECT) & rst_n;
    assign accept_s   = in_valid & in_ready;

    assign scan_sel_s  = en & (mode == MODE_SCAN);
    assign scan_load_s = scan_sel_s & (state_q != ST_SCAN);
    assign scan_run_s  = scan_sel_s & (state_q == ST_SCAN);
    assign idx_last_s  = (idx_q == {SEL_W{1'b1}});
    assign idx_inc_s   = idx_q + SEL_W'(1);

    scan_timer #(
        .DWELL_W (DWELL_W)
    ) u_scan_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (scan_load_s),
        .run      (scan_run_s),
        .dwell    (dwell),
        .idx_last (idx_last_s),
        .step     (step_s),
        .wrap     (wrap_s)
    );

    // Next state: enable dominates, otherwise the mode input picks the state.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (mode == MODE_SCAN) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_DIRECT;
        end
    end

    // Next output register values; idx is kept across disable so scan resumes.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        wrap_d      = 1'b0;
        if (!en) begin
            out_d       = {OUT_W{1'b0}};
            out_valid_d = 1'b0;
        end else if (mode == MODE_SCAN) begin
            case (state_q)
                ST_SCAN: begin
                    if (step_s) begin
                        idx_d       = idx_inc_s;
                        out_d       = OUT_W'(onehot(ONEHOT_MAX_SEL_W'(idx_inc_s)));
                        out_valid_d = 1'b1;
                        wrap_d      = wrap_s;
                    end else begin
                        out_d       = out_q;
                    end
                end
                ST_IDLE, ST_DIRECT: begin
                    out_d       = OUT_W'(onehot(ONEHOT_MAX_SEL_W'(idx_q)));
                    out_valid_d = 1'b1;
                end
                default: begin
                    out_d       = OUT_W'(onehot(ONEHOT_MAX_SEL_W'(idx_q)));
                    out_valid_d = 1'b1;
                end
            endcase
        end else begin
            if (accept_s) begin
                idx_d       = in;
                out_d       = OUT_W'(onehot(ONEHOT_MAX_SEL_W'(in)));
                out_valid_d = 1'b1;
            end else begin
                out_d       = out_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            idx_q       <= {SEL_W{1'b0}};
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: a 16-output and a 4-output instance share stimulus
// and are compared every cycle against a cycle-level behavioural model,
// with directed literal checks followed by a randomized phase.
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        in_valid;
    logic [3:0]  in_v;
    logic [7:0]  dwell;

    logic        a_in_ready, a_valid, a_wrap;
    logic [15:0] a_out;
    logic [3:0]  a_idx;
    logic        b_in_ready, b_valid, b_wrap;
    logic [3:0]  b_out;
    logic [1:0]  b_idx;
    logic [1:0]  b_in;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    assign b_in = in_v[1:0];

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(a_in_ready), .in(in_v), .dwell(dwell), .out(a_out),
        .out_valid(a_valid), .idx(a_idx), .wrap(a_wrap)
    );

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(b_in_ready), .in(b_in), .dwell(dwell), .out(b_out),
        .out_valid(b_valid), .idx(b_idx), .wrap(b_wrap)
    );

    // Behavioural model: [0] is the 16-output instance, [1] the 4-output one.
    int nout [2] = '{16, 4};
    int m_idx [2];
    int m_left [2];
    bit m_valid [2];
    bit m_scan [2];
    bit m_wrap [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_idx[i] <= 0; m_left[i] <= 0; m_valid[i] <= 1'b0;
                m_scan[i] <= 1'b0; m_wrap[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_wrap[i] <= 1'b0;
                if (!en) begin
                    m_valid[i] <= 1'b0;
                    m_scan[i]  <= 1'b0;
                end else if (mode) begin
                    if (!m_scan[i]) begin
                        m_scan[i]  <= 1'b1;
                        m_valid[i] <= 1'b1;
                        m_left[i]  <= int'(dwell);
                    end else if (m_left[i] == 0) begin
                        m_idx[i]  <= (m_idx[i] + 1) % nout[i];
                        m_left[i] <= int'(dwell);
                        m_wrap[i] <= (m_idx[i] == nout[i] - 1);
                    end else begin
                        m_left[i] <= m_left[i] - 1;
                    end
                end else begin
                    m_scan[i] <= 1'b0;
                    if (in_valid) begin
                        m_idx[i]   <= int'(in_v) % nout[i];
                        m_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_out(input int i);
        return m_valid[i] ? (32'd1 << m_idx[i]) : 32'd0;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("a_out",       32'(a_out),      exp_out(0));
            chk("a_out_valid", 32'(a_valid),    32'(m_valid[0]));
            chk("a_idx",       32'(a_idx),      32'(m_idx[0]));
            chk("a_wrap",      32'(a_wrap),     32'(m_wrap[0]));
            chk("a_in_ready",  32'(a_in_ready), 32'(en & ~mode & rst_n));
            chk("b_out",       32'(b_out),      exp_out(1));
            chk("b_out_valid", 32'(b_valid),    32'(m_valid[1]));
            chk("b_idx",       32'(b_idx),      32'(m_idx[1]));
            chk("b_wrap",      32'(b_wrap),     32'(m_wrap[1]));
            chk("b_in_ready",  32'(b_in_ready), 32'(en & ~mode & rst_n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_v = 4'd0; dwell = 8'd0;
        tick(); tick();
        cmp_on = 1'b1;
        chk("rst_out",   32'(a_out),   32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_idx",   32'(a_idx),   32'h0);
        chk("rst_wrap",  32'(a_wrap),  32'h0);
        rst_n = 1'b1;

        // Direct decode of 5, then hold with in_valid low.
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; in_v = 4'd5;
        #1 chk("dir_ready", 32'(a_in_ready), 32'h1);
        tick();
        chk("dir_out5",   32'(a_out),   32'h0020);
        chk("dir_idx5",   32'(a_idx),   32'h5);
        chk("dir_valid5", 32'(a_valid), 32'h1);
        chk("b_dir_out",  32'(b_out),   32'h2);
        in_valid = 1'b0;
        tick(); tick();
        chk("dir_hold", 32'(a_out), 32'h0020);

        // Back-to-back accepts.
        in_valid = 1'b1; in_v = 4'd0;
        tick(); chk("b2b_0",  32'(a_out), 32'h0001); chk("b2b_rdy", 32'(a_in_ready), 32'h1);
        in_v = 4'd15;
        tick(); chk("b2b_15", 32'(a_out), 32'h8000);
        in_v = 4'd3;
        tick(); chk("b2b_3",  32'(a_out), 32'h0008);
        in_v = 4'd0;
        tick();

        // Scan with dwell=2 through a full wrap.
        in_valid = 1'b0; mode = 1'b1; dwell = 8'd2;
        #1 chk("scan_ready", 32'(a_in_ready), 32'h0);
        tick();
        for (int k = 0; k < 48; k++) begin
            chk("scan_d2_out",  32'(a_out),  32'd1 << (k / 3));
            chk("scan_d2_wrap", 32'(a_wrap), 32'h0);
            tick();
        end
        chk("wrap_out",   32'(a_out),  32'h0001);
        chk("wrap_pulse", 32'(a_wrap), 32'h1);
        tick();
        chk("wrap_once",  32'(a_wrap), 32'h0);

        // Disable, then scan with dwell=0, switching to dwell=3 mid-run.
        en = 1'b0;
        tick();
        chk("dis_out",   32'(a_out),   32'h0);
        chk("dis_valid", 32'(a_valid), 32'h0);
        dwell = 8'd0; en = 1'b1;
        tick();
        for (int j = 0; j < 5; j++) begin
            chk("scan_d0_out", 32'(a_out), 32'd1 << j);
            if (j < 4) tick();
        end
        dwell = 8'd3;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("scan_d3_out5", 32'(a_out), 32'h0020);
        end
        tick(); chk("scan_d3_out6", 32'(a_out), 32'h0040);
        tick(); tick(); tick(); tick();
        chk("scan_at7", 32'(a_out), 32'h0080);

        // Disable at idx 7 and resume with a fresh dwell.
        en = 1'b0;
        tick();
        chk("en_low_out",   32'(a_out),   32'h0);
        chk("en_low_valid", 32'(a_valid), 32'h0);
        chk("en_low_idx",   32'(a_idx),   32'h7);
        en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("resume_out7", 32'(a_out), 32'h0080);
        end
        tick(); chk("resume_out8", 32'(a_out), 32'h0100);

        // Asynchronous reset mid-cycle.
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out",   32'(a_out),   32'h0);
        chk("arst_valid", 32'(a_valid), 32'h0);
        chk("arst_idx",   32'(a_idx),   32'h0);
        chk("arst_wrap",  32'(a_wrap),  32'h0);
        tick();
        rst_n = 1'b1;

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            tick();
            en       = ($urandom_range(0, 15) != 0);
            mode     = ($urandom_range(0, 23) == 0) ? ~mode : mode;
            in_valid = 1'($urandom_range(0, 1));
            in_v     = 4'($urandom);
            dwell    = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        tick();
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
